// File: rtl/mux_nne1_rr_if.sv
// Bus bundle for mux_nne1_rr: N producer channels in, one registered consumer channel out.
// Handshake: a word moves on a rising edge when its valid and ready are both 1; the
// sender holds data and valid until accepted; ready may depend combinationally on valid.
interface mux_nne1_rr_if #(
  parameter int W = 16,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] Hyrja;
  logic [N-1:0]   HyrjaValid;
  logic [N-1:0]   HyrjaReady;
  logic [W-1:0]   Dalja;
  logic           DaljaValid;
  logic           DaljaReady;
  logic [SW-1:0]  Zgjedhja;

  modport master (
    output Hyrja, HyrjaValid, DaljaReady,
    input  HyrjaReady, Dalja, DaljaValid, Zgjedhja
  );

  modport slave (
    input  Hyrja, HyrjaValid, DaljaReady,
    output HyrjaReady, Dalja, DaljaValid, Zgjedhja
  );
endinterface

// File: rtl/mux_nne1_rr.sv
// N-to-1 W-bit mux with round-robin arbitration and a one-entry output register.
// Define MUX_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module mux_nne1_rr #(
  parameter int W = 16,
  parameter int N = 4
) (
  input logic          Clock,
  input logic          Reset,
  mux_nne1_rr_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW:0] N_W = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [W-1:0]  dalja_q, dalja_d;
  logic          dalja_valid_q, dalja_valid_d;
  logic [SW-1:0] zgjedhja_q, zgjedhja_d;

  logic          load;
  logic          grant_valid;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] start_idx;
  logic [SW:0]   probe;
  logic [N-1:0]  hyrja_ready;

`ifdef MUX_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [SW-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load && grant_valid) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign load = ~dalja_valid_q | bus.DaljaReady;

  // Circular search from start_idx; the explicit wrap keeps probe below N for any N.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int k = 0; k < N; k++) begin
      probe = {1'b0, start_idx} + (SW+1)'(k);
      if (probe >= N_W) begin
        probe = probe - N_W;
      end
      if (!grant_valid && bus.HyrjaValid[probe[SW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = probe[SW-1:0];
      end
    end
  end

  always_comb begin
    hyrja_ready = '0;
    if (load && grant_valid && !Reset) begin
      hyrja_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    dalja_d       = dalja_q;
    dalja_valid_d = dalja_valid_q;
    zgjedhja_d    = zgjedhja_q;
    if (load) begin
      if (grant_valid) begin
        dalja_d       = bus.Hyrja[grant_idx*W +: W];
        zgjedhja_d    = grant_idx;
        dalja_valid_d = 1'b1;
      end else begin
        dalja_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dalja_q       <= '0;
      dalja_valid_q <= 1'b0;
      zgjedhja_q    <= '0;
    end else begin
      dalja_q       <= dalja_d;
      dalja_valid_q <= dalja_valid_d;
      zgjedhja_q    <= zgjedhja_d;
    end
  end

  assign bus.HyrjaReady = hyrja_ready;
  assign bus.Dalja      = dalja_q;
  assign bus.DaljaValid = dalja_valid_q;
  assign bus.Zgjedhja   = zgjedhja_q;
endmodule
